// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Shared definitions for the LFSR generator and its sequence
//            checker: checker state encodings, default polynomial and the
//            feedback function that defines next(x).
// Revision : 1.0  initial release
// ============================================================================
package lfsr_pkg;

    // Checker states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } state_t;

    // Default polynomial for a 3-bit word: x^3 + x^2 + 1, period 7.
    localparam int unsigned c_DEF_WIDTH = 3;
    localparam logic [2:0]  c_DEF_TAPS  = 3'b110;

    // Feedback bit of next(x) = {x[W-2:0], ^(x & TAPS)}. Callers zero-extend
    // x and TAPS to 32 bits so one definition serves every word width.
    function automatic logic lfsr_fb(input logic [31:0] x, input logic [31:0] taps);
        return ^(x & taps);
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_checker_if
// Brief    : Sample stream in, lock/error status out, for lfsr_seq_checker.
//            Optional macro LFSR_CHK_ERRCNT_EN adds the err_cnt signal.
// Revision : 1.0  initial release
// ============================================================================
interface lfsr_seq_checker_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             locked;
    logic             err;
    logic [1:0]       state;
    logic [WIDTH-1:0] expected;
`ifdef LFSR_CHK_ERRCNT_EN
    logic [15:0]      err_cnt;

    modport master (output in_valid, in_data,
                    input  locked, err, state, expected, err_cnt);
    modport slave  (input  in_valid, in_data,
                    output locked, err, state, expected, err_cnt);
`else
    modport master (output in_valid, in_data,
                    input  locked, err, state, expected);
    modport slave  (input  in_valid, in_data,
                    output locked, err, state, expected);
`endif
endinterface : lfsr_seq_checker_if
`default_nettype wire

// File: rtl/lfsr_next.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_next
// Brief    : Combinational Fibonacci LFSR step: o_next = next(i_x).
// Revision : 1.0  initial release
// ============================================================================
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(c_DEF_TAPS)
) (
    input  wire logic [WIDTH-1:0] i_x,
    output logic      [WIDTH-1:0] o_next
);

    // Shift left, tapped parity into the LSB.
    assign o_next = {i_x[WIDTH-2:0], lfsr_fb(32'(i_x), 32'(TAPS))};

endmodule : lfsr_next
`default_nettype wire

// File: rtl/lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_seq_checker
// Brief    : Predicts each next LFSR word, locks after LOCK_CNT consecutive
//            matches, pulses err on every mismatch while locked (flywheeling
//            the prediction) and drops lock after LOSS_CNT consecutive misses.
//            Optional macro LFSR_CHK_ERRCNT_EN adds a saturating error count.
// Revision : 1.0  initial release
// ============================================================================
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(c_DEF_TAPS),
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    lfsr_seq_checker_if.slave bus
);

    localparam logic [7:0] c_LOCK = 8'(LOCK_CNT);
    localparam logic [7:0] c_LOSS = 8'(LOSS_CNT);

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_expected,  w_expected_nxt;
    logic [7:0]       r_match_cnt, w_match_nxt;
    logic [7:0]       r_miss_cnt,  w_miss_nxt;
    logic             r_err,       w_err_nxt;

    logic [WIDTH-1:0] w_next_in;
    logic [WIDTH-1:0] w_next_exp;
    logic             w_match;
    logic             w_zero;

    // Prediction from the received sample (seeding / tracking).
    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next_in (
        .i_x    (bus.in_data),
        .o_next (w_next_in)
    );

    // Prediction from the current prediction (flywheel over bad samples).
    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_next_exp (
        .i_x    (r_expected),
        .o_next (w_next_exp)
    );

    assign w_match = (bus.in_data == r_expected);
    assign w_zero  = (bus.in_data == '0);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HUNT;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state logic; everything holds when no sample is presented.
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_match_nxt    = r_match_cnt;
        w_miss_nxt     = r_miss_cnt;
        w_err_nxt      = 1'b0;
        if (bus.in_valid) begin
            unique case (r_state)
                HUNT: begin
                    // All-zero is the lock-up word and cannot seed.
                    if (!w_zero) begin
                        w_expected_nxt = w_next_in;
                        w_match_nxt    = '0;
                        w_state_nxt    = SYNC;
                    end
                end
                SYNC: begin
                    if (w_match) begin
                        w_match_nxt    = r_match_cnt + 8'd1;
                        w_expected_nxt = w_next_in;
                        if (w_match_nxt == c_LOCK) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end else if (!w_zero) begin
                        w_expected_nxt = w_next_in;
                        w_match_nxt    = '0;
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_miss_nxt     = '0;
                        w_expected_nxt = w_next_in;
                    end else begin
                        w_err_nxt      = 1'b1;
                        w_miss_nxt     = r_miss_cnt + 8'd1;
                        w_expected_nxt = w_next_exp;
                        if (w_miss_nxt == c_LOSS) begin
                            w_state_nxt = HUNT;
                            w_miss_nxt  = '0;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    assign bus.locked   = (r_state == LOCKED);
    assign bus.err      = r_err;
    assign bus.state    = r_state;
    assign bus.expected = r_expected;

`ifdef LFSR_CHK_ERRCNT_EN
    logic [15:0] r_err_cnt;

    // Saturating total of err pulses; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_err_nxt && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`endif

endmodule : lfsr_seq_checker
`default_nettype wire

// File: tb/tb_lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_seq_checker
// Brief    : Directed scoreboard bench for lfsr_seq_checker (default
//            parameters; honours LFSR_CHK_ERRCNT_EN when defined).
// Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_seq_checker;

    typedef struct {
        logic [1:0] st;
        logic [2:0] ex;
        logic       er;
        int         cnt;
        string      nm;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;
    bit   stim_done;

    lfsr_seq_checker_if #(.WIDTH(3)) bus ();

    lfsr_seq_checker #(
        .WIDTH    (3),
        .TAPS     (3'b110),
        .LOCK_CNT (4),
        .LOSS_CNT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, then queue the outputs expected after that edge.
    task automatic step(input logic rst, input logic v, input logic [2:0] d,
                        input logic [1:0] es, input logic [2:0] ee,
                        input logic eerr, input int ecnt, input string nm);
        exp_t e;
        reset        = rst;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        e.st = es; e.ex = ee; e.er = eerr; e.cnt = ecnt; e.nm = nm;
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: compare registered outputs mid-cycle.
    initial begin
        exp_t e;
        n_tests = 0;
        n_fail  = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (bus.state !== e.st) begin
                    n_fail++;
                    $display("FAIL %s state: got %b want %b", e.nm, bus.state, e.st);
                end
                n_tests++;
                if (bus.locked !== (e.st == 2'b10)) begin
                    n_fail++;
                    $display("FAIL %s locked: got %b want %b", e.nm, bus.locked, (e.st == 2'b10));
                end
                n_tests++;
                if (bus.expected !== e.ex) begin
                    n_fail++;
                    $display("FAIL %s expected: got %b want %b", e.nm, bus.expected, e.ex);
                end
                n_tests++;
                if (bus.err !== e.er) begin
                    n_fail++;
                    $display("FAIL %s err: got %b want %b", e.nm, bus.err, e.er);
                end
`ifdef LFSR_CHK_ERRCNT_EN
                n_tests++;
                if (bus.err_cnt !== 16'(e.cnt)) begin
                    n_fail++;
                    $display("FAIL %s err_cnt: got %0d want %0d", e.nm, bus.err_cnt, e.cnt);
                end
`endif
            end
        end
    end

    logic [2:0] t5_seq [5];

    initial begin
        stim_done    = 1'b0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 3'b000;

        // Clean lock from seed 111.
        step(1, 0, 3'b000, 2'b00, 3'b000, 0, 0, "rst");
        step(0, 1, 3'b111, 2'b01, 3'b110, 0, 0, "t1_seed");
        step(0, 1, 3'b110, 2'b01, 3'b100, 0, 0, "t1_m1");
        step(0, 1, 3'b100, 2'b01, 3'b001, 0, 0, "t1_m2");
        step(0, 1, 3'b001, 2'b01, 3'b010, 0, 0, "t1_m3");
        step(0, 1, 3'b010, 2'b10, 3'b101, 0, 0, "t1_lock");

        // Single corrupted word while locked: flywheel over it.
        step(0, 1, 3'b101, 2'b10, 3'b011, 0, 0, "t3_ok");
        step(0, 1, 3'b000, 2'b10, 3'b111, 1, 1, "t3_bad");
        step(0, 1, 3'b111, 2'b10, 3'b110, 0, 1, "t3_resume");
        step(0, 0, 3'b111, 2'b10, 3'b110, 0, 1, "t3_idle");

        // Three consecutive misses drop lock; clean stream relocks.
        step(0, 1, 3'b000, 2'b10, 3'b100, 1, 2, "t4_miss1");
        step(0, 1, 3'b000, 2'b10, 3'b001, 1, 3, "t4_miss2");
        step(0, 1, 3'b000, 2'b00, 3'b010, 1, 4, "t4_loss");
        step(0, 1, 3'b111, 2'b01, 3'b110, 0, 4, "t4_seed");
        step(0, 1, 3'b110, 2'b01, 3'b100, 0, 4, "t4_m1");
        step(0, 1, 3'b100, 2'b01, 3'b001, 0, 4, "t4_m2");
        step(0, 1, 3'b001, 2'b01, 3'b010, 0, 4, "t4_m3");
        step(0, 1, 3'b010, 2'b10, 3'b101, 0, 4, "t4_relock");

        // Zeros ignored in HUNT; SYNC reseeds on nonzero miss, hunts on zero.
        step(1, 0, 3'b000, 2'b00, 3'b000, 0, 0, "t2_rst");
        for (int i = 0; i < 3; i++)
            step(0, 1, 3'b000, 2'b00, 3'b000, 0, 0, "t2_zero");
        step(0, 1, 3'b111, 2'b01, 3'b110, 0, 0, "t2_seed");
        step(0, 1, 3'b011, 2'b01, 3'b111, 0, 0, "t2_reseed");
        step(0, 1, 3'b000, 2'b00, 3'b111, 0, 0, "t2_zero_hunt");

        // Lock with in_valid toggling and data held between valids.
        step(1, 0, 3'b000, 2'b00, 3'b000, 0, 0, "t5_rst");
        t5_seq[0] = 3'b111; t5_seq[1] = 3'b110; t5_seq[2] = 3'b100;
        t5_seq[3] = 3'b001; t5_seq[4] = 3'b010;
        step(0, 1, t5_seq[0], 2'b01, 3'b110, 0, 0, "t5_v0");
        step(0, 0, t5_seq[0], 2'b01, 3'b110, 0, 0, "t5_hold0");
        step(0, 1, t5_seq[1], 2'b01, 3'b100, 0, 0, "t5_v1");
        step(0, 0, t5_seq[1], 2'b01, 3'b100, 0, 0, "t5_hold1");
        step(0, 1, t5_seq[2], 2'b01, 3'b001, 0, 0, "t5_v2");
        step(0, 0, t5_seq[2], 2'b01, 3'b001, 0, 0, "t5_hold2");
        step(0, 1, t5_seq[3], 2'b01, 3'b010, 0, 0, "t5_v3");
        step(0, 0, t5_seq[3], 2'b01, 3'b010, 0, 0, "t5_hold3");
        step(0, 1, t5_seq[4], 2'b10, 3'b101, 0, 0, "t5_lock");
        step(0, 0, t5_seq[4], 2'b10, 3'b101, 0, 0, "t5_hold4");

        // Miss while locked, then reset (with valid high) overrides everything.
        step(0, 1, 3'b000, 2'b10, 3'b011, 1, 1, "t6_miss");
        step(1, 1, 3'b101, 2'b00, 3'b000, 0, 0, "t6_reset");
        step(0, 1, 3'b111, 2'b01, 3'b110, 0, 0, "t6_seed");

        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        stim_done = 1'b1;
    end

    // Summary once stimulus finishes, bounded by a global time limit.
    initial begin
        fork
            wait (stim_done);
            #100000;
        join_any
        disable fork;
        n_tests++;
        if (!stim_done || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: done=%0b pending=%0d want done=1 pending=0",
                     stim_done, sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lfsr_seq_checker
`default_nettype wire

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

Downstream consumer of the `lfsr` pseudo-random generator. Samples the generator's `q` word stream and predicts each next word with the same Fibonacci polynomial. Acquires lock after a run of correct predictions, flags every mismatch once locked, and drops lock after consecutive misses. Used as the self-check stage on generator outputs and as the receive side of PRBS link tests.

## Interface
- `WIDTH`, 3: word width; matches generator `q`.
- `TAPS`, 3'b110: feedback tap mask (x^3+x^2+1, maximal length 7).
- `LOCK_CNT`, 4: consecutive matches required to lock (1..255).
- `LOSS_CNT`, 3: consecutive mismatches that drop lock (1..255).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `in_data` is a generator sample this cycle.
- `in_data`  in  WIDTH  generator word (`q`).
- `locked`  out  1  high while in LOCKED.
- `err`  out  1  one-cycle pulse per mismatch while LOCKED.
- `state`  out  2  HUNT=00, SYNC=01, LOCKED=10 (11 unused).
- `expected`  out  WIDTH  predicted value of the next valid sample.
- `err_cnt`  out  16  mismatch total (only with `LFSR_CHK_ERRCNT_EN`).

## Operation
- next(x) = {x[WIDTH-2:0], ^(x & TAPS)}: shift left, parity of tapped bits into the LSB.
- `in_valid`=0: all registers hold; `err`=0.
- HUNT: a nonzero sample sets `expected`=next(sample), match_cnt=0, and moves to SYNC. An all-zero sample is the lock-up word; it is ignored and the block stays in HUNT.
- SYNC: a sample equal to `expected` gives match_cnt+1 and `expected`=next(sample). When match_cnt reaches LOCK_CNT, the block moves to LOCKED with miss_cnt=0. On a mismatch, a nonzero sample reseeds (`expected`=next(sample), match_cnt=0, stay in SYNC); a zero sample returns to HUNT. No `err` pulse in SYNC.
- LOCKED: on a match, miss_cnt=0 and `expected`=next(sample). On a mismatch, `err`=1, miss_cnt+1, and `expected`=next(`expected`): flywheel, the bad sample is not used. When miss_cnt reaches LOSS_CNT, the block moves to HUNT; `expected` is then don't-care until reseeded.
- match_cnt and miss_cnt are 8 bits each. The terminal comparison is equality, so neither counter wraps.
- Reset during any state overrides all other behaviour at that edge.

## Timing
- All outputs are registered. They update on the edge that captures a valid sample and are visible the following cycle.
- Reset values: `locked`=0, `err`=0, `state`=00, `expected`=0, `err_cnt`=0; internal counters 0.
- Lock latency with continuous valid and a clean stream: seed sample plus LOCK_CNT matching samples. `locked` rises after LOCK_CNT+1 valid edges.
- `err` is high for exactly one cycle, the cycle after the offending sample. Consecutive bad samples give back-to-back pulses.
- Loss: `locked` falls after the edge capturing the LOSS_CNT-th consecutive mismatch. That sample still pulses `err`.

## Configuration
- `LFSR_CHK_ERRCNT_EN` defined:
  - `err_cnt` port exists.
  - It increments on every `err` pulse and saturates at 16'hFFFF.
  - Only reset clears it; loss of lock does not.
- Macro undefined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Shared package/header `lfsr_pkg` holds:
  - state encodings HUNT/SYNC/LOCKED;
  - default TAPS for WIDTH 3;
  - the next() definition, shared with the generator so both sides use one polynomial.
- One combinational sub-module `lfsr_next` (parameters WIDTH, TAPS; in x, out next(x)). It is instantiated twice: once on `in_data` and once on `expected`.

## Test plan
Defaults apply; the reference sequence from seed 111 is 111,110,100,001,010,101,011.
- Reset, then continuous valid stream 111,110,100,001,010 → `locked`=1 after the 5th sample edge; `expected`=101; `err` never asserted.
- Reset, then 000 ×3 followed by 111 → `state` stays 00 during the zeros, then goes to 01 with `expected`=110.
- While locked, corrupt one sample (send 000 in place of 001), then resume with 010 → single `err` pulse, `locked` stays 1, no error on 010. With the macro, `err_cnt`=1.
- While locked, send 3 consecutive wrong words → 3 `err` pulses and `locked`=0 after the 3rd. A subsequent clean stream relocks after 5 valid samples.
- Lock sequence with `in_valid` toggling every cycle and data held between valids → locks after 5 valid samples (about 10 cycles); no `err`.
- Assert `reset` for one cycle while LOCKED → the next cycle shows `state`=00, `locked`=0, `expected`=0, `err_cnt`=0.
